alu_seq_exec: RTL and testbench
===============================

Name: alu_seq_exec

Overview:
- Parametrised ALU execute stage for the KGP-RISC datapath.
- Decodes aluop/funct internally, so no separate control-signal bus is needed.
- Executes logic/arithmetic ops in one cycle and shifts iteratively, one bit per cycle.
- Uses valid/ready handshakes on both sides, so the pipeline can stall on multi-cycle shifts.

Parameters:
- DATA_W, 32, operand/result width.
- SHAMT_W, 5, shift-amount width. Constraint: 2**SHAMT_W == DATA_W.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request; high only in IDLE.
- aluop  input  3  op class from main control.
- funct  input  6  function field.
- op_a  input  DATA_W  operand A; the shifted value for shifts.
- op_b  input  DATA_W  operand B; shift amount is op_b[SHAMT_W-1:0].
- out_valid  output  1  result valid; held until accepted.
- out_ready  input  1  consumer accepts result.
- result  output  DATA_W  registered result.
- carry  output  1  ADD carry-out, or last bit shifted out; 0 otherwise.
- zero  output  1  result == 0.
- sign  output  1  result[DATA_W-1].
- illegal  output  1  undecodable aluop/funct pair.

Behaviour:
- Decode (aluop, funct):
  - 000/1 ADD a+b; 000/2 COMP (~b)+1; 000/3 AND.
  - 001/1 XOR; 001/2 OR.
  - 010/0 SLL; 010/1 SRL; 010/2 SRA.
  - 101/1 ADD (address calc); 110/1 COMP.
  - Any other pair is illegal.
- Reset (async, rst_n low): state IDLE, count 0, out_valid 0, result 0, carry/zero/sign/illegal 0. in_ready=1 while in IDLE. Takes effect immediately, including mid-shift; any in-flight op is discarded.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - Accept when in_valid & in_ready.
  - Non-shift or illegal op: compute into result/flags, go to DONE. out_valid rises the cycle after accept (latency 1).
  - Shift with shamt==0: result=op_a, carry=0, go to DONE (latency 1).
  - Shift with shamt>0: load result=op_a, count=shamt, go to SHIFT.
- SHIFT:
  - Each cycle shift result by 1: SLL fills 0, SRL fills 0, SRA replicates the MSB.
  - carry = bit shifted out; count decrements.
  - When count reaches 1 this cycle, go to DONE.
  - Latency from accept to out_valid = shamt+1 cycles.
- DONE:
  - out_valid=1; result/flags held stable.
  - On out_ready go to IDLE; out_valid drops the next cycle.
  - A new request is not accepted in the same cycle.
- in_ready = (state==IDLE). Inputs are ignored in SHIFT/DONE.
- Arithmetic:
  - ADD computed at DATA_W+1 bits; carry = bit DATA_W.
  - COMP carry=0.
  - Logic ops carry=0.
  - zero/sign are always derived from the final result.
- Illegal op: result=0, illegal=1, carry=0, zero=1, sign=0. Completes through DONE like any other op.
- illegal is cleared when the next request is accepted.

Optional Feature:
- Macro: ALU_BARREL_SHIFT_EN.
- Defined: shifts are computed in one cycle by a barrel shifter. The SHIFT state and counter are not built; every op has latency 1. carry = last bit shifted out (op_a bit at DATA_W-shamt for SLL, bit shamt-1 for SRL/SRA; 0 if shamt==0).
- Undefined: iterative 1-bit/cycle shifter as described in Behaviour.

Test Plan:
- ADD: aluop=000, funct=1, a=0xFFFFFFFF, b=0x1 -> one cycle after accept: result=0x00000000, carry=1, zero=1, out_valid=1.
- SRA: aluop=010, funct=2, a=0x80000000, b=4 -> out_valid 5 cycles after accept, result=0xF8000000, sign=1, carry=0. With ALU_BARREL_SHIFT_EN: same values after 1 cycle.
- SLL: funct=0, a=0x1, b=0 -> latency 1, result=0x1, carry=0. SRL: a=0x3, b=1 -> result=0x1, carry=1.
- Illegal: aluop=011, funct=1 -> next cycle out_valid=1, illegal=1, result=0, zero=1. The following legal op clears illegal.
- Backpressure: out_ready held low 3 cycles after an AND result -> result/flags stable, in_ready=0, in_valid ignored. out_ready=1 -> IDLE, in_ready=1 next cycle.
- Reset: rst_n pulsed low 2 cycles into SLL shamt=20 -> outputs 0 immediately. After release: in_ready=1, no out_valid from the aborted op.

Source files
------------

// File: rtl/alu_seq_exec.sv
// ALU execute stage: single-cycle logic/arithmetic, iterative 1-bit/cycle shifts, valid/ready.
// Define ALU_BARREL_SHIFT_EN to replace the iterative shifter with a single-cycle barrel shifter.
`timescale 1ns/1ps
module alu_seq_exec #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        aluop,
  input  logic [5:0]        funct,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              zero,
  output logic              sign,
  output logic              illegal
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;
  typedef enum logic [3:0] {OpAdd, OpComp, OpAnd, OpXor, OpOr, OpSll, OpSrl, OpSra, OpIll} op_e;

  localparam logic [DATA_W-1:0] OneW = DATA_W'(1);

  state_e              state_q;
  logic [DATA_W-1:0]   result_q;
  logic                carry_q, zero_q, sign_q, illegal_q;
  op_e                 op;
  logic [SHAMT_W-1:0]  shamt;
  logic [DATA_W:0]     sum;
  logic [DATA_W-1:0]   calc_res;
  logic                calc_carry;
  logic                is_shift;

  assign shamt    = op_b[SHAMT_W-1:0];
  assign sum      = {1'b0, op_a} + {1'b0, op_b};
  assign is_shift = (op == OpSll) || (op == OpSrl) || (op == OpSra);

  always_comb begin
    op = OpIll;
    case ({aluop, funct})
      {3'b000, 6'd1}, {3'b101, 6'd1}: op = OpAdd;
      {3'b000, 6'd2}, {3'b110, 6'd1}: op = OpComp;
      {3'b000, 6'd3}:                 op = OpAnd;
      {3'b001, 6'd1}:                 op = OpXor;
      {3'b001, 6'd2}:                 op = OpOr;
      {3'b010, 6'd0}:                 op = OpSll;
      {3'b010, 6'd1}:                 op = OpSrl;
      {3'b010, 6'd2}:                 op = OpSra;
      default:                        op = OpIll;
    endcase
  end

`ifdef ALU_BARREL_SHIFT_EN
  // Double-width shifts expose the last bit shifted out at a fixed position.
  logic [2*DATA_W-1:0] sll_w, srl_w, sra_w;
  assign sll_w = {{DATA_W{1'b0}}, op_a} << shamt;
  assign srl_w = {op_a, {DATA_W{1'b0}}} >> shamt;
  assign sra_w = $signed({op_a, {DATA_W{1'b0}}}) >>> shamt;
`else
  logic [SHAMT_W-1:0]  count_q;
  op_e                 shop_q;
  logic [DATA_W-1:0]   step_res;
  logic                step_carry;

  always_comb begin
    step_res   = result_q;
    step_carry = 1'b0;
    case (shop_q)
      OpSll: begin
        step_res   = {result_q[DATA_W-2:0], 1'b0};
        step_carry = result_q[DATA_W-1];
      end
      OpSrl: begin
        step_res   = {1'b0, result_q[DATA_W-1:1]};
        step_carry = result_q[0];
      end
      OpSra: begin
        step_res   = {result_q[DATA_W-1], result_q[DATA_W-1:1]};
        step_carry = result_q[0];
      end
      default: ;
    endcase
  end
`endif

  always_comb begin
    calc_res   = '0;
    calc_carry = 1'b0;
    case (op)
      OpAdd: begin
        calc_res   = sum[DATA_W-1:0];
        calc_carry = sum[DATA_W];
      end
      OpComp: calc_res = ~op_b + OneW;
      OpAnd:  calc_res = op_a & op_b;
      OpXor:  calc_res = op_a ^ op_b;
      OpOr:   calc_res = op_a | op_b;
`ifdef ALU_BARREL_SHIFT_EN
      OpSll: begin
        calc_res   = sll_w[DATA_W-1:0];
        calc_carry = sll_w[DATA_W];
      end
      OpSrl: begin
        calc_res   = srl_w[2*DATA_W-1:DATA_W];
        calc_carry = srl_w[DATA_W-1];
      end
      OpSra: begin
        calc_res   = sra_w[2*DATA_W-1:DATA_W];
        calc_carry = sra_w[DATA_W-1];
      end
`else
      // Only reached with shamt == 0; nonzero amounts go through StShift.
      OpSll, OpSrl, OpSra: calc_res = op_a;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      result_q  <= '0;
      carry_q   <= 1'b0;
      zero_q    <= 1'b0;
      sign_q    <= 1'b0;
      illegal_q <= 1'b0;
`ifndef ALU_BARREL_SHIFT_EN
      count_q   <= '0;
      shop_q    <= OpIll;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            illegal_q <= (op == OpIll);
`ifndef ALU_BARREL_SHIFT_EN
            if (is_shift && (shamt != '0)) begin
              result_q <= op_a;
              carry_q  <= 1'b0;
              count_q  <= shamt;
              shop_q   <= op;
              state_q  <= StShift;
            end else
`endif
            begin
              result_q <= calc_res;
              carry_q  <= calc_carry;
              zero_q   <= (calc_res == '0);
              sign_q   <= calc_res[DATA_W-1];
              state_q  <= StDone;
            end
          end
        end
        StShift: begin
`ifndef ALU_BARREL_SHIFT_EN
          result_q <= step_res;
          carry_q  <= step_carry;
          count_q  <= count_q - SHAMT_W'(1);
          if (count_q == SHAMT_W'(1)) begin
            zero_q  <= (step_res == '0);
            sign_q  <= step_res[DATA_W-1];
            state_q <= StDone;
          end
`else
          state_q <= StIdle;
`endif
        end
        StDone: begin
          if (out_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef ALU_BARREL_SHIFT_EN
  // Shift class is irrelevant when every op completes in one cycle.
  logic unused_shift;
  assign unused_shift = is_shift;
`endif

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign result    = result_q;
  assign carry     = carry_q;
  assign zero      = zero_q;
  assign sign      = sign_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_seq_exec.sv
// Randomized bench for alu_seq_exec against a transaction-level reference model.
`timescale 1ns/1ps
module tb_alu_seq_exec;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  aluop = '0;
  logic [5:0]  funct = '0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        carry, zero, sign, illegal;

  always #5 clk = ~clk;

  alu_seq_exec #(.DATA_W(32), .SHAMT_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .aluop     (aluop),
    .funct     (funct),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry     (carry),
    .zero      (zero),
    .sign      (sign),
    .illegal   (illegal)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: result, carry, illegal flag and accept-to-valid latency of one request.
  function automatic void model(input logic [2:0] op, input logic [5:0] f,
                                input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic c, output logic ill,
                                output int lat);
    logic [32:0] s;
    logic [63:0] t;
    int sh;
    sh  = int'(b[4:0]);
    r   = '0;
    c   = 1'b0;
    ill = 1'b0;
    lat = 1;
    case ({op, f})
      {3'd0, 6'd1}, {3'd5, 6'd1}: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[31:0];
        c = s[32];
      end
      {3'd0, 6'd2}, {3'd6, 6'd1}: r = 32'd0 - b;
      {3'd0, 6'd3}: r = a & b;
      {3'd1, 6'd1}: r = a ^ b;
      {3'd1, 6'd2}: r = a | b;
      {3'd2, 6'd0}: begin
        t = {32'd0, a} << sh;
        r = t[31:0];
        c = t[32];
        lat = sh + 1;
      end
      {3'd2, 6'd1}: begin
        t = {a, 32'd0} >> sh;
        r = t[63:32];
        c = t[31];
        lat = sh + 1;
      end
      {3'd2, 6'd2}: begin
        t = $signed({a, 32'd0}) >>> sh;
        r = t[63:32];
        c = t[31];
        lat = sh + 1;
      end
      default: ill = 1'b1;
    endcase
`ifdef ALU_BARREL_SHIFT_EN
    lat = 1;
`endif
  endfunction

  // Model state: whether a request is outstanding, and the cycle its result becomes visible.
  bit          active = 1'b0;
  int          cyc = 0;
  int          exp_ov_cyc = 0;
  int          m_lat;
  logic [31:0] e_res = '0;
  logic        e_c = 1'b0;
  logic        e_ill = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active = 1'b0;
    end else begin
      if (active) begin
        if (out_ready && cyc >= exp_ov_cyc) active = 1'b0;
      end else if (in_valid) begin
        model(aluop, funct, op_a, op_b, e_res, e_c, e_ill, m_lat);
        active     = 1'b1;
        exp_ov_cyc = cyc + m_lat;
      end
      cyc = cyc + 1;
    end
  end

  always @(negedge clk) begin
    bit ev;
    if (!rst_n) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_result", result, 0);
      chk("rst_flags", {carry, zero, sign, illegal}, 0);
    end else begin
      ev = active && (cyc >= exp_ov_cyc);
      chk("out_valid", out_valid, ev);
      chk("in_ready", in_ready, !active);
      if (ev) begin
        chk("result", result, e_res);
        chk("flags", {carry, zero, sign, illegal},
            {e_c, e_res == 32'd0, e_res[31], e_ill});
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic garbage;
    in_valid = 1'b1;
    aluop    = 3'($urandom);
    funct    = 6'($urandom);
    op_a     = $urandom;
    op_b     = $urandom;
  endtask

  // Issue one request, wait for its result, hold it for 'hold' cycles, then release it.
  task automatic run_op(input logic [2:0] op, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input int hold,
                        output logic [31:0] r, output logic [3:0] fl, output int lat_seen);
    in_valid = 1'b1;
    aluop    = op;
    funct    = f;
    op_a     = a;
    op_b     = b;
    tick;
    lat_seen = 1;
    garbage;
    while (!out_valid && lat_seen < 200) begin
      tick;
      lat_seen++;
    end
    if (!out_valid) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout: out_valid still 0 after %0d cycles, expected 1", lat_seen);
    end
    r  = result;
    fl = {carry, zero, sign, illegal};
    repeat (hold) tick;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
  endtask

  logic [31:0] r;
  logic [3:0]  fl;
  int          lat;
  int          shift_lat;
  logic [8:0]  legal [10] = '{9'h001, 9'h002, 9'h003, 9'h041, 9'h042,
                              9'h080, 9'h081, 9'h082, 9'h141, 9'h181};
  logic [8:0]  pair;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick;

    run_op(3'd0, 6'd1, 32'hFFFF_FFFF, 32'h1, 0, r, fl, lat);
    chk("add_res", r, 32'h0);
    chk("add_flags", fl, 4'b1100);
    chk("add_lat", lat, 1);

`ifdef ALU_BARREL_SHIFT_EN
    shift_lat = 1;
`else
    shift_lat = 5;
`endif
    run_op(3'd2, 6'd2, 32'h8000_0000, 32'd4, 0, r, fl, lat);
    chk("sra_res", r, 32'hF800_0000);
    chk("sra_flags", fl, 4'b0010);
    chk("sra_lat", lat, shift_lat);

    run_op(3'd2, 6'd0, 32'h1, 32'd0, 0, r, fl, lat);
    chk("sll0_res", r, 32'h1);
    chk("sll0_flags", fl, 4'b0000);
    chk("sll0_lat", lat, 1);

    run_op(3'd2, 6'd1, 32'h3, 32'd1, 0, r, fl, lat);
    chk("srl1_res", r, 32'h1);
    chk("srl1_flags", fl, 4'b1000);

    run_op(3'd3, 6'd1, 32'h1234_5678, 32'h9, 0, r, fl, lat);
    chk("ill_res", r, 32'h0);
    chk("ill_flags", fl, 4'b0101);
    chk("ill_lat", lat, 1);

    run_op(3'd1, 6'd1, 32'h5, 32'h3, 0, r, fl, lat);
    chk("xor_res", r, 32'h6);
    chk("xor_clears_illegal", fl, 4'b0000);

    run_op(3'd0, 6'd3, 32'hF0F0_F0F0, 32'hFF00_FF00, 3, r, fl, lat);
    chk("and_res", r, 32'hF000_F000);
    chk("and_flags", fl, 4'b0010);
    chk("bp_in_ready_after", in_ready, 1);

    run_op(3'd6, 6'd1, 32'h0, 32'h1, 0, r, fl, lat);
    chk("comp_res", r, 32'hFFFF_FFFF);
    chk("comp_flags", fl, 4'b0010);

    // Abort a long shift with reset partway through.
    in_valid = 1'b1;
    aluop    = 3'd2;
    funct    = 6'd0;
    op_a     = 32'h0000_0F0F;
    op_b     = 32'd20;
    tick;
    in_valid = 1'b0;
    tick;
    tick;
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_result", result, 0);
    chk("abort_flags", {carry, zero, sign, illegal}, 0);
    chk("abort_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (25) tick;
    chk("abort_no_valid", out_valid, 0);

    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 11) < 10) pair = legal[$urandom_range(0, 9)];
      else pair = 9'($urandom);
      run_op(pair[8:6], pair[5:0], $urandom, $urandom, $urandom_range(0, 3), r, fl, lat);
      if ($urandom_range(0, 3) == 0) tick;
    end

    repeat (2) tick;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
